perf_sampler: RTL

PERF_SAMPLER -- requirements
Module: perf_sampler

---
 rtl/npu_pkg.sv | 37 +++
 rtl/perf_interval_timer.sv | 30 +++
 rtl/perf_sampler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared constants for the NPU performance counter block and its sampler:
// register map, sweep read order, CTRL encodings and sampler FSM states.
package npu_pkg;

  localparam int PERF_NUM_WORDS = 18;

  // Register map of the perf counter block
  localparam logic [7:0] PERF_CTRL_ADDR     = 8'h00;
  localparam logic [7:0] PERF_CYC_LO_ADDR   = 8'h10;
  localparam logic [7:0] PERF_CYC_HI_ADDR   = 8'h14;
  localparam logic [7:0] PERF_EVT_BASE_ADDR = 8'h20;
  localparam logic [7:0] PERF_EVT_LAST_ADDR = 8'h5C;

  // CTRL encodings: bit0 EN, bit1 RESET, bit2 FREEZE
  localparam logic [7:0] PERF_CTRL_OFF       = 8'h00;
  localparam logic [7:0] PERF_CTRL_EN        = 8'h01;
  localparam logic [7:0] PERF_CTRL_EN_RESET  = 8'h03;
  localparam logic [7:0] PERF_CTRL_EN_FREEZE = 8'h05;

  // Sweep read order, each 64-bit counter LO word before its HI word
  localparam logic [0:PERF_NUM_WORDS-1][7:0] PERF_RD_TABLE = {
    PERF_CYC_LO_ADDR, PERF_CYC_HI_ADDR,
    PERF_EVT_BASE_ADDR, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C,
    8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, PERF_EVT_LAST_ADDR
  };

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_FRZ  = 3'd2,
    ST_RD   = 3'd3,
    ST_UNF  = 3'd4,
    ST_EMIT = 3'd5,
    ST_STOP = 3'd6
  } perf_state_e;

endpackage

// File: rtl/perf_interval_timer.sv
// Periodic sample timer: counts down from the configured interval and pulses
// tick when it reaches 1, reloading on the same cycle. An interval of 0 keeps
// the counter parked at 0, so it never ticks.
module perf_interval_timer #(
  parameter int IVL_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load,
  input  logic [IVL_WIDTH-1:0] interval,
  output logic                 tick
);

  logic [IVL_WIDTH-1:0] cnt;

  // A forced load (sampler INIT) masks any tick in the same cycle
  assign tick = enable && !load && (cnt == IVL_WIDTH'(1));

  // Countdown with reload; the interval is only sampled on a reload
  always_ff @(posedge clk) begin
    if (rst)                            cnt <= '0;
    else if (load)                      cnt <= interval;
    else if (enable) begin
      if (cnt <= IVL_WIDTH'(1))         cnt <= interval;
      else                              cnt <= cnt - IVL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/perf_sampler.sv
// Perf counter sampler: drives the perf block's register bus to snapshot all
// 18 counter words (optionally under FREEZE) and streams each snapshot as a
// 19-beat record (sequence number + words) with valid/ready handshaking.
module perf_sampler
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IVL_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic                  cfg_freeze,
  input  logic [IVL_WIDTH-1:0]  cfg_interval,
  input  logic                  trig,
  output logic                  reg_wr,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic [DATA_WIDTH-1:0] smp_data,
  output logic                  smp_last,
  output logic                  busy,
  output logic [15:0]           overrun_cnt
);

  localparam logic [4:0] LAST_WORD = 5'(PERF_NUM_WORDS - 1);
  localparam logic [4:0] LAST_BEAT = 5'(PERF_NUM_WORDS);

  perf_state_e           state;
  logic                  en_q;    // enable level as last acknowledged in IDLE
  logic                  frz_q;   // freeze choice latched at sample start
  logic [4:0]            idx;     // word index in RD, beat index in EMIT
  logic [31:0]           seq;
  logic [DATA_WIDTH-1:0] rd_buf [PERF_NUM_WORDS];
  logic                  tick;
  logic                  req;
  logic [4:0]            bidx;

  // Requests from either source; trig only counts while enabled
  assign req = tick || (trig && cfg_enable);

  perf_interval_timer #(.IVL_WIDTH(IVL_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (cfg_enable),
    .load     (state == ST_INIT),
    .interval (cfg_interval),
    .tick     (tick)
  );

  // Main sequencer. Enable edges are only acted on from IDLE, so an enable
  // drop mid-record is remembered in en_q and handled once the record ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      en_q  <= 1'b0;
      frz_q <= 1'b0;
      idx   <= '0;
      seq   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_enable && !en_q) begin
            en_q  <= 1'b1;
            state <= ST_INIT;
          end else if (!cfg_enable && en_q) begin
            en_q  <= 1'b0;
            state <= ST_STOP;
          end else if (req) begin
            frz_q <= cfg_freeze;
            idx   <= '0;
            state <= cfg_freeze ? ST_FRZ : ST_RD;
          end
        end
        ST_INIT: begin
          seq   <= '0;
          state <= ST_IDLE;
        end
        ST_FRZ: state <= ST_RD;
        ST_RD: begin
          if (idx == LAST_WORD) begin
            idx   <= '0;
            state <= frz_q ? ST_UNF : ST_EMIT;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        ST_UNF: state <= ST_EMIT;
        ST_EMIT: begin
          if (smp_ready) begin
            if (idx == LAST_BEAT) begin
              idx   <= '0;
              seq   <= seq + 32'd1;
              state <= ST_IDLE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot buffer: word i is captured in the RD cycle that addresses it
  always_ff @(posedge clk) begin
    if (state == ST_RD) rd_buf[idx] <= reg_rdata;
  end

  // Dropped requests while a record is in flight, saturating
  always_ff @(posedge clk) begin
    if (rst)                                   overrun_cnt <= '0;
    else if (state != ST_IDLE && req && overrun_cnt != 16'hFFFF)
                                               overrun_cnt <= overrun_cnt + 16'd1;
  end

  // Register-bus drive decoded from state
  always_comb begin
    reg_wr    = 1'b0;
    reg_addr  = ADDR_WIDTH'(PERF_CTRL_ADDR);
    reg_wdata = '0;
    case (state)
      ST_INIT: begin reg_wr = 1'b1; reg_wdata = DATA_WIDTH'(PERF_CTRL_EN_RESET);  end
      ST_FRZ:  begin reg_wr = 1'b1; reg_wdata = DATA_WIDTH'(PERF_CTRL_EN_FREEZE); end
      ST_UNF:  begin reg_wr = 1'b1; reg_wdata = DATA_WIDTH'(PERF_CTRL_EN);        end
      ST_STOP: begin reg_wr = 1'b1; reg_wdata = DATA_WIDTH'(PERF_CTRL_OFF);       end
      ST_RD:   reg_addr = ADDR_WIDTH'(PERF_RD_TABLE[idx]);
      default: ;
    endcase
  end

  // Sample stream: beat 0 is the sequence number, beats 1..18 the buffer
  always_comb begin
    bidx      = (idx == 5'd0) ? 5'd0 : idx - 5'd1;
    smp_valid = (state == ST_EMIT);
    smp_last  = smp_valid && (idx == LAST_BEAT);
    smp_data  = '0;
    if (smp_valid) smp_data = (idx == 5'd0) ? DATA_WIDTH'(seq) : rd_buf[bidx];
  end

  assign busy = (state != ST_IDLE);

endmodule
